spi_wrapper: RTL and testbench

SPI slave front end combined with a 256×8 single-port RAM. The block receives 10-bit command words serially on MOSI, one bit per clk edge while SS_n is low. It writes RAM, sets addresses, and returns read data serially on MISO. It sits between an external SPI master, clocked synchronously with clk, and on-chip storage.

---
 rtl/spi_wrapper.sv | 139 +++++++++++++
 tb/tb_spi_wrapper.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/spi_wrapper.sv
// spi_wrapper: SPI slave front end with a 256x8 single-port RAM.
// Takes 10-bit command words on MOSI, MSB first, while SS_n is low.
// Bits [9:8] of each word select an action on the RAM; bits [7:0] carry the payload.
// Read data goes back on MISO, MSB first.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous reset, active HIGH (the name is historical)
//   MOSI  - serial command/data in
//   MISO  - serial read data out, registered, 0 when idle
//   SS_n  - slave select, active low; high aborts or ends a frame
module spi_wrapper (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    output logic MISO,
    input  logic SS_n
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t      state, state_nxt;
    logic [8:0]  rx_sr;        // bits 9..1 of the word in flight
    logic [3:0]  bit_cnt;      // bits still to come before bit 0
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  mem [0:255];
    logic [7:0]  write_addr, read_addr, dout;
    logic        tx_valid, rd_addr_ok;
    logic        got_word;     // READ_DATA: word received, now waiting on or sending dout
    logic        tx_active;
    logic [2:0]  tx_left;
    logic [6:0]  tx_sr;
    logic        shifting, last_bit, tx_last;

    always_comb begin
        shifting  = (state == WRITE) || (state == READ_ADD) ||
                    ((state == READ_DATA) && !got_word);
        last_bit  = shifting && (bit_cnt == 4'd0);
        tx_last   = (state == READ_DATA) && tx_active && (tx_left == 3'd1);
        state_nxt = state;
        case (state)
            IDLE:      if (!SS_n) state_nxt = CHK_CMD;
            CHK_CMD:   state_nxt = MOSI ? (rd_addr_ok ? READ_DATA : READ_ADD) : WRITE;
            WRITE,
            READ_ADD:  if (last_bit) state_nxt = CHK_CMD;
            READ_DATA: begin
                // If bit 8 of the word is 0, the word is not a data read.
                // Nothing will be sent, so the word ends here.
                if (last_bit && !rx_sr[7]) state_nxt = CHK_CMD;
                else if (tx_last)          state_nxt = CHK_CMD;
            end
            default:   state_nxt = IDLE;
        endcase
        if (SS_n) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            write_addr <= '0;
            read_addr  <= '0;
            dout       <= '0;
            tx_valid   <= 1'b0;
            rd_addr_ok <= 1'b0;
            got_word   <= 1'b0;
            tx_active  <= 1'b0;
            tx_left    <= '0;
            tx_sr      <= '0;
            MISO       <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_valid <= 1'b0;
            tx_valid <= 1'b0;
            MISO     <= 1'b0;
            got_word <= (state_nxt == READ_DATA) && (got_word || last_bit);

            // receive
            if (!SS_n) begin
                if (state == CHK_CMD) begin
                    rx_sr   <= {rx_sr[7:0], MOSI};
                    bit_cnt <= 4'd8;
                end else if (shifting) begin
                    if (bit_cnt == 4'd0) begin
                        rx_data  <= {rx_sr, MOSI};
                        rx_valid <= 1'b1;
                    end else begin
                        rx_sr   <= {rx_sr[7:0], MOSI};
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
            end

            // RAM command decode (the memory write itself is below)
            if (rx_valid) begin
                case (rx_data[9:8])
                    2'b00: write_addr <= rx_data[7:0];
                    2'b10: begin
                        read_addr  <= rx_data[7:0];
                        rd_addr_ok <= 1'b1;
                    end
                    2'b11: begin
                        dout     <= mem[read_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // transmit: only a word taken in READ_DATA is sent out
            if ((state == READ_DATA) && !SS_n) begin
                if (tx_valid && got_word && !tx_active) begin
                    MISO      <= dout[7];
                    tx_sr     <= dout[6:0];
                    tx_left   <= 3'd7;
                    tx_active <= 1'b1;
                end else if (tx_active) begin
                    MISO    <= tx_sr[6];
                    tx_sr   <= {tx_sr[5:0], 1'b0};
                    tx_left <= tx_left - 3'd1;
                    if (tx_left == 3'd1) begin
                        tx_active  <= 1'b0;
                        rd_addr_ok <= 1'b0;
                    end
                end
            end else begin
                tx_active <= 1'b0;
            end
        end
    end

    // Memory contents are not reset. Writes are held off during reset.
    always_ff @(posedge clk) begin
        if (!rst_n && rx_valid && (rx_data[9:8] == 2'b01))
            mem[write_addr] <= rx_data[7:0];
    end
endmodule

// File: tb/tb_spi_wrapper.sv
module tb_spi_wrapper;
    logic clk = 1'b0;
    logic rst_n, MOSI, SS_n, MISO;
    int   n_vec = 0;
    int   n_err = 0;
    logic miso_or;
    logic [7:0] got;

    spi_wrapper dut (.clk(clk), .rst_n(rst_n), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one rising edge with the given SS_n/MOSI, then settle
    task automatic step(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            step(1'b0, w[i]);
            miso_or = miso_or | MISO;
        end
    endtask

    // E0..E10, then SS_n high for two edges so the RAM action lands
    task automatic frame(input logic [9:0] w);
        step(1'b0, 1'b0);
        send_word(w);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    // read-data frame: E0..E19 low, E20 high
    task automatic read_frame(input logic [9:0] w, output logic [7:0] d);
        d = '0;
        step(1'b0, 1'b0);
        send_word(w);
        step(1'b0, 1'b0);                       // E11
        check("miso_e11", 32'(MISO), 32'd0);
        for (int i = 0; i < 8; i++) begin       // E12..E19
            step(1'b0, 1'b0);
            d = {d[6:0], MISO};
        end
        step(1'b1, 1'b0);                       // E20
        check("miso_e20", 32'(MISO), 32'd0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1; SS_n = 1'b1; MOSI = 1'b0; miso_or = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        check("rst_rx_valid", 32'(dut.rx_valid), 32'd0);
        check("rst_tx_valid", 32'(dut.tx_valid), 32'd0);
        check("rst_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd0);
        rst_n = 1'b0;
        step(1'b1, 1'b0);

        // back-to-back write addr 0 then data 0xFF
        step(1'b0, 1'b0);
        send_word(10'h000);
        send_word(10'h1FF);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("t1_mem00", 32'(dut.mem[0]), 32'h0FF);
        check("t1_miso_quiet", 32'(miso_or), 32'd0);

        // read address 0, then read data
        frame(10'h200);
        check("t2_rd_ok_set", 32'(dut.rd_addr_ok), 32'd1);
        read_frame(10'h300, got);
        check("t2_data", 32'(got), 32'h0FF);
        check("t2_rd_ok_clr", 32'(dut.rd_addr_ok), 32'd0);

        // 0xAA at 0x0F
        frame(10'h00F);
        frame(10'h1AA);
        frame(10'h20F);
        read_frame(10'h300, got);
        check("t3_data", 32'(got), 32'h0AA);

        // 0x3A at 0xF0, 0x0F still intact
        frame(10'h0F0);
        frame(10'h13A);
        frame(10'h2F0);
        read_frame(10'h300, got);
        check("t4_data", 32'(got), 32'h03A);
        check("t4_memF0", 32'(dut.mem[8'hF0]), 32'h03A);
        frame(10'h20F);
        read_frame(10'h300, got);
        check("t4_data0F", 32'(got), 32'h0AA);

        // abort a write-data word after 5 bits
        frame(10'h010);
        frame(10'h111);
        step(1'b0, 1'b0);
        for (int i = 9; i >= 5; i--) begin
            logic [9:0] w;
            w = 10'h155;
            step(1'b0, w[i]);
        end
        step(1'b1, 1'b0);
        check("t5_state_idle", 32'(dut.state), 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("t5_no_write", 32'(dut.mem[8'h10]), 32'h011);
        frame(10'h1C3);
        frame(10'h210);
        read_frame(10'h300, got);
        check("t5_after_abort", 32'(got), 32'h0C3);

        // reset in the middle of sending 0xAA
        frame(10'h20F);
        step(1'b0, 1'b0);
        send_word(10'h300);
        step(1'b0, 1'b0);                       // E11
        step(1'b0, 1'b0);                       // E12: bit7 = 1
        check("t6_bit7", 32'(MISO), 32'd1);
        step(1'b0, 1'b0);                       // E13: bit6 = 0
        step(1'b0, 1'b0);                       // E14: bit5 = 1
        check("t6_bit5", 32'(MISO), 32'd1);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        check("t6_miso", 32'(MISO), 32'd0);
        check("t6_state", 32'(dut.state), 32'd0);
        check("t6_rd_ok", 32'(dut.rd_addr_ok), 32'd0);
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("t6_miso_idle", 32'(MISO), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
